// File: rtl/rom_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// jsilicon_pkg
//   Shared definitions for the ROM sequencer that feeds cpu_a / cpu_b /
//   cpu_opcode to the mode switch while the chip runs its built-in program.
//   Contents:
//     - ALU opcode encodings (OP_*)
//     - ROM word width and field layout (rom_word_t)
//     - sequencer FSM state encoding (seq_state_t, 2 bits)
//     - default program words and the halt word returned for unused addresses
// ---------------------------------------------------------------------------
package jsilicon_pkg;

  // ALU opcodes understood downstream.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam int ROM_WORD_W = 20;

  // ROM word layout: {halt[19], opcode[18:16], a[15:8], b[7:0]}.
  typedef struct packed {
    logic       halt;
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } rom_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // Builds a ROM word from its fields.
  function automatic logic [ROM_WORD_W-1:0] make_word(
    input logic       halt,
    input logic [2:0] opcode,
    input logic [7:0] a,
    input logic [7:0] b
  );
    rom_word_t w;
    w.halt   = halt;
    w.opcode = opcode;
    w.a      = a;
    w.b      = b;
    return w;
  endfunction

  // Any address not holding a program word reads as a bare halt.
  localparam logic [ROM_WORD_W-1:0] HALT_WORD = 20'h80000;

  // Default program: three ALU operations followed by a halt.
  localparam logic [ROM_WORD_W-1:0] PROG_0 = {1'b0, OP_ADD, 8'd3,  8'd5};
  localparam logic [ROM_WORD_W-1:0] PROG_1 = {1'b0, OP_SUB, 8'd10, 8'd4};
  localparam logic [ROM_WORD_W-1:0] PROG_2 = {1'b0, OP_MUL, 8'd6,  8'd7};
  localparam logic [ROM_WORD_W-1:0] PROG_3 = HALT_WORD;

endpackage

// File: rtl/seq_rom.sv
// ---------------------------------------------------------------------------
// seq_rom
//   Combinational case-table ROM holding the built-in program.
//   Addresses outside the program return HALT_WORD so a runaway PC always
//   stops (or wraps) cleanly.
// Parameters
//   PCW   address width
// Ports
//   addr  in   PCW  word address (the sequencer's program counter)
//   word  out  20   {halt, opcode[2:0], a[7:0], b[7:0]}
// ---------------------------------------------------------------------------
module seq_rom
  import jsilicon_pkg::*;
#(
  parameter int PCW = 4
) (
  input  logic [PCW-1:0]        addr,
  output logic [ROM_WORD_W-1:0] word
);

  // Widen once so the case labels stay valid for any PCW.
  logic [31:0] addr_ext;
  assign addr_ext = 32'(addr);

  always_comb begin
    word = HALT_WORD;
    case (addr_ext)
      32'd0:   word = PROG_0;
      32'd1:   word = PROG_1;
      32'd2:   word = PROG_2;
      32'd3:   word = PROG_3;
      default: word = HALT_WORD;
    endcase
  end

endmodule

// File: rtl/rom_sequencer.sv
// ---------------------------------------------------------------------------
// rom_sequencer
//   Steps a program counter through the built-in ROM and presents each
//   instruction on cpu_a / cpu_b / cpu_opcode for STEP_CYCLES+1 clocks so the
//   downstream ALU and display can settle. A halt word or the last ROM address
//   ends the program in DONE.
//
// Build option
//   SEQ_LOOP_EN  when defined, a halt word or the last ROM address wraps the PC
//                to 0 and keeps running (valid stays 1, halted never set).
//
// Parameters
//   ROM_DEPTH    number of ROM words (power of two); pc width = clog2(ROM_DEPTH)
//   STEP_CYCLES  HOLD length of each instruction in clocks (>= 1)
//
// Ports
//   clk         in   1    system clock, rising edge
//   reset       in   1    asynchronous, active-high reset
//   ena         in   1    global enable; 0 freezes all state
//   mode        in   1    1 = ROM run, 0 = manual (forces IDLE)
//   start       in   1    level-sampled (re)start request from IDLE or DONE
//   pause       in   1    freezes the step timer while in HOLD
//   cpu_a       out  8    operand A of the current instruction
//   cpu_b       out  8    operand B of the current instruction
//   cpu_opcode  out  3    opcode of the current instruction
//   valid       out  1    cpu_* carry a live instruction
//   pc          out  PCW  current program counter
//   halted      out  1    sequencer is in DONE
// ---------------------------------------------------------------------------
module rom_sequencer
  import jsilicon_pkg::*;
#(
  parameter  int ROM_DEPTH   = 16,
  parameter  int STEP_CYCLES = 4,
  localparam int PCW         = $clog2(ROM_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
  input  logic           mode,
  input  logic           start,
  input  logic           pause,
  output logic [7:0]     cpu_a,
  output logic [7:0]     cpu_b,
  output logic [2:0]     cpu_opcode,
  output logic           valid,
  output logic [PCW-1:0] pc,
  output logic           halted
);

  // Timer counts STEP_CYCLES-1 down to 0; keep at least one bit.
  localparam int             TW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LOAD = TW'(STEP_CYCLES - 1);
  localparam logic [PCW-1:0] PC_LAST    = PCW'(ROM_DEPTH - 1);

  seq_state_t     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     a_q, a_d;
  logic [7:0]     b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic           valid_q, valid_d;
  logic           halted_q, halted_d;

  logic [ROM_WORD_W-1:0] rom_raw;
  rom_word_t             rom_w;

  seq_rom #(
    .PCW (PCW)
  ) u_rom (
    .addr (pc_q),
    .word (rom_raw)
  );

  assign rom_w = rom_word_t'(rom_raw);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    timer_d  = timer_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    if (!mode) begin
      // Leaving ROM mode wins over everything and scrubs the outputs.
      state_d  = ST_IDLE;
      pc_d     = '0;
      timer_d  = '0;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_d    = '0;
            state_d = ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (rom_w.halt) begin
`ifdef SEQ_LOOP_EN
            // Wrap: the previous instruction stays on the bus while PC 0 loads.
            pc_d    = '0;
            state_d = ST_LOAD;
`else
            // cpu_* keep the last instruction; only valid drops.
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_DONE;
`endif
          end else begin
            a_d     = rom_w.a;
            b_d     = rom_w.b;
            op_d    = rom_w.opcode;
            valid_d = 1'b1;
            timer_d = TIMER_LOAD;
            state_d = ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (!pause) begin
            if (timer_q != '0) begin
              timer_d = timer_q - TW'(1);
            end else if (pc_q == PC_LAST) begin
`ifdef SEQ_LOOP_EN
              pc_d    = '0;
              state_d = ST_LOAD;
`else
              valid_d  = 1'b0;
              halted_d = 1'b1;
              state_d  = ST_DONE;
`endif
            end else begin
              pc_d    = pc_q + PCW'(1);
              state_d = ST_LOAD;
            end
          end
        end

        ST_DONE: begin
          if (start) begin
            pc_d     = '0;
            halted_d = 1'b0;
            state_d  = ST_LOAD;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State register; ena=0 freezes everything.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      timer_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else if (ena) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      timer_q  <= timer_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign cpu_a      = a_q;
  assign cpu_b      = b_q;
  assign cpu_opcode = op_q;
  assign valid      = valid_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_sequencer
//   Scoreboard bench for rom_sequencer (ROM_DEPTH=16, STEP_CYCLES=4).
//   The stimulus process drives inputs on the falling edge, advances a
//   reference model and pushes the outputs expected after the next rising
//   edge. A monitor pops one entry after every rising edge and compares.
//   The model tracks "effective cycles since the program was started" and
//   derives instruction index, pc and valid from it arithmetically.
// ---------------------------------------------------------------------------
module tb_rom_sequencer;

  localparam int S   = 4;       // STEP_CYCLES
  localparam int N   = 3;       // live instructions before the halt word
  localparam int PER = S + 1;   // clocks each instruction is presented

  logic       clk;
  logic       reset;
  logic       ena;
  logic       mode;
  logic       start;
  logic       pause;
  logic [7:0] cpu_a;
  logic [7:0] cpu_b;
  logic [2:0] cpu_opcode;
  logic       valid;
  logic [3:0] pc;
  logic       halted;

  rom_sequencer #(
    .ROM_DEPTH   (16),
    .STEP_CYCLES (S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .mode       (mode),
    .start      (start),
    .pause      (pause),
    .cpu_a      (cpu_a),
    .cpu_b      (cpu_b),
    .cpu_opcode (cpu_opcode),
    .valid      (valid),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       valid;
    logic [3:0] pc;
    logic       halted;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Program as written in the ROM table.
  int prog_a  [N] = '{3, 10, 6};
  int prog_b  [N] = '{5, 4, 7};
  int prog_op [N] = '{0, 1, 2};

  typedef enum { PH_IDLE, PH_RUN, PH_DONE } phase_t;
  phase_t m_phase = PH_IDLE;
  int     m_e     = 0;         // effective cycles since start accepted
  exp_t   m_out   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.a = cpu_a; o.b = cpu_b; o.op = cpu_opcode;
    o.valid = valid; o.pc = pc; o.halted = halted;
    return o;
  endfunction

  // True when effective cycle e is a HOLD cycle (where pause acts).
  function automatic bit in_hold(input int e);
    int c;
    if (e < 1) return 1'b0;
    c = e - 1;
`ifdef SEQ_LOOP_EN
    c = c % (N * PER + 1);
    if (c == N * PER) return 1'b0;
`endif
    return (c % PER) < S;
  endfunction

  // Recompute expected outputs from the model phase.
  task automatic model_out();
    int c, k, pos;
    case (m_phase)
      PH_IDLE: m_out = '0;
      PH_DONE: begin
        m_out.a = 8'(prog_a[N-1]); m_out.b = 8'(prog_b[N-1]); m_out.op = 3'(prog_op[N-1]);
        m_out.valid = 1'b0; m_out.pc = 4'(N); m_out.halted = 1'b1;
      end
      default: begin
        m_out.halted = 1'b0;
        if (m_e == 0) begin
          // Program just accepted: previous cpu_* remain, nothing live yet.
          m_out.pc = 4'd0; m_out.valid = 1'b0;
        end else begin
          c = m_e - 1;
`ifdef SEQ_LOOP_EN
          c = c % (N * PER + 1);
`endif
          if (c >= N * PER) begin
            // Wrap cycle: PC 0 is loading, last instruction still live.
            k = N - 1; m_out.pc = 4'd0;
          end else begin
            k = c / PER; pos = c % PER;
            m_out.pc = (pos == S) ? 4'(k + 1) : 4'(k);
          end
          m_out.a = 8'(prog_a[k]); m_out.b = 8'(prog_b[k]); m_out.op = 3'(prog_op[k]);
          m_out.valid = 1'b1;
        end
      end
    endcase
  endtask

  task automatic model_step(input logic r, input logic m, input logic s, input logic p, input logic e);
    if (r) m_phase = PH_IDLE;
    else if (e) begin
      if (!m) m_phase = PH_IDLE;
      else case (m_phase)
        PH_IDLE, PH_DONE: if (s) begin m_phase = PH_RUN; m_e = 0; end
        default: if (!(p && in_hold(m_e))) begin
          m_e++;
`ifndef SEQ_LOOP_EN
          if (m_e > N * PER) m_phase = PH_DONE;
`endif
        end
      endcase
    end
    model_out();
  endtask

  // One clock of stimulus: drive on the falling edge, predict, enqueue.
  task automatic cycle(input logic r, input logic m, input logic s, input logic p, input logic e);
    @(negedge clk);
    reset = r; mode = m; start = s; pause = p; ena = e;
    if (r) begin
      #1;
      check("reset_async", 32'(dut_out()), 32'd0);
    end
    model_step(r, m, s, p, e);
    exp_q.push_back(m_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every rising edge that has a prediction queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 32'(dut_out()), 32'(e));
      end
    end
  end

  initial begin
    reset = 1'b1; ena = 1'b0; mode = 1'b0; start = 1'b0; pause = 1'b0;

    // Reset, then release with mode=0: must stay idle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full program run into DONE.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run(20);

    // Restart from DONE, pause 10 clocks during instruction 1.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !(m_out.pc == 4'd1 && m_out.a == 8'd10); i++) run(1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(20);

    // Mode drop while pc=2, then mode=1 without start stays idle.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_out.pc != 4'd2; i++) run(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(4);

    // ena low for 3 clocks in HOLD, then resume.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(20);

    // Async reset mid-HOLD, released with mode=0.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run(8);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(logic'($urandom_range(0, 199) == 0),
            logic'($urandom_range(0, 19) != 0),
            logic'($urandom_range(0, 9) == 0),
            logic'($urandom_range(0, 4) == 0),
            logic'($urandom_range(0, 7) != 0));
    end

    repeat (2) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
